mem_bus_if: RTL and testbench
=============================

MEM_BUS_IF -- requirements
Module: mem_bus_if

Interface
Parameters
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, setting the maximum cycles a transfer may wait for wb_ack_i; legal range 1..255.

Ports
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset: synchronous, active-high.
REQ-004 SHALL have port stall_i, input, 6, the pipeline stall vector; bit 4 means the MEM stage is held.
REQ-005 SHALL have port flush_i, input, 1, the pipeline flush (exception); aborts any pending transfer.
REQ-006 SHALL have ports cpu_ce_i (1), cpu_we_i (1), cpu_addr_i (32), cpu_sel_i (4) and cpu_data_i (32), inputs, the MEM-stage access request.
REQ-007 SHALL have port cpu_data_o, output, 32, the read data returned to the MEM stage.
REQ-008 SHALL have port stallreq_o, output, 1, the pipeline stall request while an access is outstanding.
REQ-009 SHALL have ports wb_cyc_o (1), wb_stb_o (1), wb_we_o (1), wb_adr_o (32), wb_sel_o (4) and wb_dat_o (32), outputs, the Wishbone-classic master.
REQ-010 SHALL have ports wb_dat_i (32) and wb_ack_i (1), inputs, the Wishbone slave response.
REQ-011 SHALL have port bus_err_o, output, 1, a one-cycle pulse on timeout.

Function
REQ-012 SHALL implement a registered FSM with states IDLE, BUSY and WAIT_STALL.
REQ-013 IDLE: SHALL, when cpu_ce_i=1 and flush_i=0, register wb_cyc_o=wb_stb_o=1 and copy cpu_we_i/addr/sel/data onto wb_we_o/adr/sel/dat_o, clear the timeout counter, and go to BUSY.
REQ-014 BUSY with wb_ack_i=1: SHALL register cyc/stb/we=0, adr/sel/dat_o=0, and latch wb_dat_i into rd_buf when wb_we_o=0; next state WAIT_STALL if stall_i[4]=1, else IDLE.
REQ-015 BUSY with flush_i=1: SHALL drop cyc/stb next edge, return to IDLE and not update rd_buf; flush takes priority over ack.
REQ-016 BUSY with no ack: SHALL increment the timeout counter; when it reaches TIMEOUT_CYCLES-1 SHALL drop cyc/stb, set rd_buf=0, pulse bus_err_o for one cycle, and go to IDLE.
REQ-017 WAIT_STALL: SHALL hold the bus idle and go to IDLE on the first cycle with stall_i[4]=0; flush_i=1 also forces IDLE.
REQ-018 stallreq_o SHALL be combinational: 1 in IDLE when cpu_ce_i=1 and flush_i=0; 1 in BUSY when wb_ack_i=0 and no timeout this cycle; 0 otherwise, including always in WAIT_STALL.
REQ-019 cpu_data_o SHALL equal wb_dat_i in a BUSY cycle with wb_ack_i=1 and wb_we_o=0; otherwise rd_buf.
REQ-020 Wishbone outputs SHALL be stable from the start of BUSY until the ack edge; at most one transfer is outstanding.
REQ-021 wb_ack_i SHALL be ignored outside BUSY.
REQ-022 Ack in the first BUSY cycle SHALL give a total access latency of 2 cycles from the cpu_ce_i rise (request edge plus ack cycle).

Reset
REQ-023 With rst=1 at a clock edge, SHALL go to IDLE, and SHALL set wb_cyc_o, wb_stb_o, wb_we_o and bus_err_o to 0; wb_adr_o, wb_dat_o and rd_buf to 0x00000000; wb_sel_o to 4'b0000; and the timeout counter to 0.
REQ-024 Reset during BUSY SHALL abandon the transfer; a late ack after reset is ignored.
REQ-025 stallreq_o SHALL be 0 while rst=1.

Verification
REQ-026 Read: cpu_ce_i=1, we=0, addr=0x00000104, sel=1111; slave acks 3 cycles later with 0xDEADBEEF -> stallreq_o=1 for 3 cycles, cpu_data_o=0xDEADBEEF in the ack cycle and after, cyc drops next edge.
REQ-027 Write: we=1, addr=0x00000200, sel=0011, data=0x0000A5A5; ack in the first BUSY cycle -> wb_dat_o=0x0000A5A5, wb_sel_o=0011, wb_we_o=1 for exactly 1 cycle, rd_buf unchanged.
REQ-028 Ack while stall_i[4]=1 for 2 more cycles -> FSM in WAIT_STALL, no new cyc, stallreq_o=0, back in IDLE when stall_i[4]=0.
REQ-029 flush_i=1 in the same cycle as ack in BUSY -> cyc drops, rd_buf keeps its old value, FSM in IDLE.
REQ-030 TIMEOUT_CYCLES=4, no ack -> bus_err_o pulses once on the 4th BUSY cycle, cpu_data_o=0, stallreq_o releases.
REQ-031 rst=1 mid-BUSY followed by a stray ack -> all outputs at reset values, no rd_buf update.

Source files
------------

// File: rtl/mem_bus_if.sv
// MEM-stage to Wishbone-classic bridge: one outstanding access at a time,
// with a bounded ack wait, flush abort and a hold-off state while the pipeline stays stalled.
module mem_bus_if #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  stall_i,
   input  logic        flush_i,
   input  logic        cpu_ce_i,
   input  logic        cpu_we_i,
   input  logic [31:0] cpu_addr_i,
   input  logic [3:0]  cpu_sel_i,
   input  logic [31:0] cpu_data_i,
   output logic [31:0] cpu_data_o,
   output logic        stallreq_o,
   output logic        wb_cyc_o,
   output logic        wb_stb_o,
   output logic        wb_we_o,
   output logic [31:0] wb_adr_o,
   output logic [3:0]  wb_sel_o,
   output logic [31:0] wb_dat_o,
   input  logic [31:0] wb_dat_i,
   input  logic        wb_ack_i,
   output logic        bus_err_o
);

   typedef enum logic [1:0] {IDLE, BUSY, WAIT_STALL} state_t;

   typedef struct packed {
      logic        we;
      logic [31:0] adr;
      logic [3:0]  sel;
      logic [31:0] dat;
   } wb_req_t;

   localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

   state_t      state_q, state_d;
   wb_req_t     req_q, req_d;
   logic        cyc_q, cyc_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [31:0] rd_buf_q, rd_buf_d;
   logic        err_q, err_d;
   logic        timeout;
   logic        mem_stall;

   // Only the MEM-stage hold bit matters to this block.
   logic unused_stall;
   assign unused_stall = ^{stall_i[5], stall_i[3:0]};
   assign mem_stall    = stall_i[4];

   // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
   always_comb begin
      state_d    = state_q;
      req_d      = req_q;
      cyc_d      = cyc_q;
      cnt_d      = cnt_q;
      rd_buf_d   = rd_buf_q;
      err_d      = 1'b0;
      timeout    = 1'b0;
      stallreq_o = 1'b0;
      cpu_data_o = rd_buf_q;

      case (state_q)
         IDLE: begin
            if (cpu_ce_i && !flush_i) begin
               stallreq_o = 1'b1;
               cyc_d      = 1'b1;
               req_d      = '{we: cpu_we_i, adr: cpu_addr_i, sel: cpu_sel_i, dat: cpu_data_i};
               cnt_d      = '0;
               state_d    = BUSY;
            end
         end
         BUSY: begin
            if (wb_ack_i && !req_q.we)
               cpu_data_o = wb_dat_i;
            if (flush_i) begin
               cyc_d   = 1'b0;
               req_d   = '0;
               state_d = IDLE;
            end else if (wb_ack_i) begin
               cyc_d   = 1'b0;
               req_d   = '0;
               if (!req_q.we)
                  rd_buf_d = wb_dat_i;
               state_d = mem_stall ? WAIT_STALL : IDLE;
            end else if (cnt_q == TO_LAST) begin
               timeout  = 1'b1;
               cyc_d    = 1'b0;
               req_d    = '0;
               rd_buf_d = '0;
               err_d    = 1'b1;
               state_d  = IDLE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
            stallreq_o = !wb_ack_i && !timeout;
         end
         WAIT_STALL: begin
            if (flush_i || !mem_stall)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (rst)
         stallreq_o = 1'b0;
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         req_q    <= '0;
         cyc_q    <= 1'b0;
         cnt_q    <= '0;
         rd_buf_q <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         req_q    <= req_d;
         cyc_q    <= cyc_d;
         cnt_q    <= cnt_d;
         rd_buf_q <= rd_buf_d;
         err_q    <= err_d;
      end
   end

   assign wb_cyc_o  = cyc_q;
   assign wb_stb_o  = cyc_q;
   assign wb_we_o   = req_q.we;
   assign wb_adr_o  = req_q.adr;
   assign wb_sel_o  = req_q.sel;
   assign wb_dat_o  = req_q.dat;
   assign bus_err_o = err_q;

endmodule

// File: tb/tb_mem_bus_if.sv
// Directed bench for mem_bus_if: read, write, stall hold-off, flush, timeout and reset
// abort, each checked against hand-computed values.
module tb_mem_bus_if;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  stall_i;
   logic        flush_i;
   logic        cpu_ce_i;
   logic        cpu_we_i;
   logic [31:0] cpu_addr_i;
   logic [3:0]  cpu_sel_i;
   logic [31:0] cpu_data_i;
   logic [31:0] cpu_data_o;
   logic        stallreq_o;
   logic        wb_cyc_o;
   logic        wb_stb_o;
   logic        wb_we_o;
   logic [31:0] wb_adr_o;
   logic [3:0]  wb_sel_o;
   logic [31:0] wb_dat_o;
   logic [31:0] wb_dat_i;
   logic        wb_ack_i;
   logic        bus_err_o;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mem_bus_if #(.TIMEOUT_CYCLES(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .stall_i    (stall_i),
      .flush_i    (flush_i),
      .cpu_ce_i   (cpu_ce_i),
      .cpu_we_i   (cpu_we_i),
      .cpu_addr_i (cpu_addr_i),
      .cpu_sel_i  (cpu_sel_i),
      .cpu_data_i (cpu_data_i),
      .cpu_data_o (cpu_data_o),
      .stallreq_o (stallreq_o),
      .wb_cyc_o   (wb_cyc_o),
      .wb_stb_o   (wb_stb_o),
      .wb_we_o    (wb_we_o),
      .wb_adr_o   (wb_adr_o),
      .wb_sel_o   (wb_sel_o),
      .wb_dat_o   (wb_dat_o),
      .wb_dat_i   (wb_dat_i),
      .wb_ack_i   (wb_ack_i),
      .bus_err_o  (bus_err_o)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one cycle; inputs change and outputs are sampled 1-2 time units after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic request(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                          input logic [31:0] dat);
      cpu_ce_i   = 1'b1;
      cpu_we_i   = we;
      cpu_addr_i = adr;
      cpu_sel_i  = sel;
      cpu_data_i = dat;
   endtask

   initial begin
      rst = 1'b1; stall_i = '0; flush_i = 1'b0;
      cpu_ce_i = 1'b0; cpu_we_i = 1'b0; cpu_addr_i = '0; cpu_sel_i = '0; cpu_data_i = '0;
      wb_dat_i = '0; wb_ack_i = 1'b0;
      tick(); tick();

      // Reset state, with a request pending that must not raise stallreq
      cpu_ce_i = 1'b1; #1;
      check("rst_stallreq", stallreq_o, 0);
      check("rst_cyc",      wb_cyc_o,   0);
      check("rst_adr",      wb_adr_o,   32'h0);
      check("rst_sel",      wb_sel_o,   4'h0);
      check("rst_err",      bus_err_o,  0);
      check("rst_cpu_data", cpu_data_o, 32'h0);
      cpu_ce_i = 1'b0;
      tick();
      rst = 1'b0;

      // Read: slave acks in the third BUSY cycle
      request(1'b0, 32'h0000_0104, 4'hF, 32'h0); #1;
      check("rd_stallreq_req", stallreq_o, 1);
      check("rd_cyc_req",      wb_cyc_o,   0);
      tick(); #1;
      check("rd_cyc_b1",      wb_cyc_o,   1);
      check("rd_stb_b1",      wb_stb_o,   1);
      check("rd_we_b1",       wb_we_o,    0);
      check("rd_adr_b1",      wb_adr_o,   32'h0000_0104);
      check("rd_sel_b1",      wb_sel_o,   4'hF);
      check("rd_stallreq_b1", stallreq_o, 1);
      tick(); #1;
      check("rd_stallreq_b2", stallreq_o, 1);
      check("rd_adr_b2",      wb_adr_o,   32'h0000_0104);
      tick();
      wb_ack_i = 1'b1; wb_dat_i = 32'hDEAD_BEEF; #1;
      check("rd_stallreq_ack", stallreq_o, 0);
      check("rd_data_ack",     cpu_data_o, 32'hDEAD_BEEF);
      tick();
      wb_ack_i = 1'b0; wb_dat_i = '0; cpu_ce_i = 1'b0; #1;
      check("rd_cyc_after",  wb_cyc_o,   0);
      check("rd_adr_after",  wb_adr_o,   32'h0);
      check("rd_data_after", cpu_data_o, 32'hDEAD_BEEF);

      // Write with ack in the first BUSY cycle
      request(1'b1, 32'h0000_0200, 4'b0011, 32'h0000_A5A5);
      tick();
      wb_ack_i = 1'b1; wb_dat_i = 32'h1111_2222; #1;
      check("wr_dat_o",     wb_dat_o,   32'h0000_A5A5);
      check("wr_sel",       wb_sel_o,   4'b0011);
      check("wr_we",        wb_we_o,    1);
      check("wr_adr",       wb_adr_o,   32'h0000_0200);
      check("wr_stallreq",  stallreq_o, 0);
      check("wr_data_ack",  cpu_data_o, 32'hDEAD_BEEF);
      tick();
      wb_ack_i = 1'b0; cpu_ce_i = 1'b0; #1;
      check("wr_we_after",   wb_we_o,    0);
      check("wr_cyc_after",  wb_cyc_o,   0);
      check("wr_rdbuf_kept", cpu_data_o, 32'hDEAD_BEEF);

      // Ack while the MEM stage stays held for two more cycles
      request(1'b0, 32'h0000_0300, 4'hF, 32'h0);
      tick();
      wb_ack_i = 1'b1; wb_dat_i = 32'h1234_5678; stall_i = 6'b01_0000; #1;
      check("st_stallreq_ack", stallreq_o, 0);
      tick();
      wb_dat_i = 32'hFFFF_FFFF; #1;
      check("st_cyc_w1",      wb_cyc_o,   0);
      check("st_stallreq_w1", stallreq_o, 0);
      check("st_data_w1",     cpu_data_o, 32'h1234_5678);
      tick(); #1;
      check("st_cyc_w2",      wb_cyc_o,   0);
      check("st_stallreq_w2", stallreq_o, 0);
      stall_i = '0; wb_ack_i = 1'b0; wb_dat_i = '0; #1;
      check("st_stallreq_rel", stallreq_o, 0);
      check("st_cyc_rel",      wb_cyc_o,   0);
      tick(); #1;
      check("st_idle_ce", stallreq_o, 1);
      check("st_data_end", cpu_data_o, 32'h1234_5678);
      cpu_ce_i = 1'b0;

      // Flush in the same cycle as ack
      request(1'b0, 32'h0000_0400, 4'hF, 32'h0);
      tick();
      wb_ack_i = 1'b1; flush_i = 1'b1; wb_dat_i = 32'hCAFE_F00D;
      tick();
      wb_ack_i = 1'b0; flush_i = 1'b0; wb_dat_i = '0; cpu_ce_i = 1'b0; #1;
      check("fl_cyc",   wb_cyc_o,   0);
      check("fl_rdbuf", cpu_data_o, 32'h1234_5678);
      cpu_ce_i = 1'b1; #1;
      check("fl_idle_ce", stallreq_o, 1);
      cpu_ce_i = 1'b0; #1;

      // Timeout: four BUSY cycles without ack
      request(1'b0, 32'h0000_0500, 4'hF, 32'h0);
      tick(); #1;
      check("to_stallreq_b1", stallreq_o, 1);
      check("to_err_b1",      bus_err_o,  0);
      tick(); tick(); #1;
      check("to_stallreq_b3", stallreq_o, 1);
      check("to_err_b3",      bus_err_o,  0);
      tick(); #1;
      check("to_stallreq_b4", stallreq_o, 0);
      check("to_cyc_b4",      wb_cyc_o,   1);
      check("to_err_b4",      bus_err_o,  0);
      tick();
      cpu_ce_i = 1'b0; #1;
      check("to_err_pulse", bus_err_o,  1);
      check("to_cyc_drop",  wb_cyc_o,   0);
      check("to_cpu_data",  cpu_data_o, 32'h0);
      check("to_stallreq",  stallreq_o, 0);
      tick(); #1;
      check("to_err_clear", bus_err_o, 0);

      // Reset mid-BUSY followed by a stray ack
      request(1'b1, 32'h0000_0600, 4'hC, 32'h5555_AAAA);
      tick(); #1;
      check("rs_cyc_busy", wb_cyc_o, 1);
      rst = 1'b1; #1;
      check("rs_stallreq_in_rst", stallreq_o, 0);
      tick();
      rst = 1'b0; cpu_ce_i = 1'b0; cpu_we_i = 1'b0;
      wb_ack_i = 1'b1; wb_dat_i = 32'hBADB_AD00; #1;
      check("rs_cyc",      wb_cyc_o,   0);
      check("rs_stb",      wb_stb_o,   0);
      check("rs_we",       wb_we_o,    0);
      check("rs_adr",      wb_adr_o,   32'h0);
      check("rs_sel",      wb_sel_o,   4'h0);
      check("rs_dat",      wb_dat_o,   32'h0);
      check("rs_err",      bus_err_o,  0);
      check("rs_stallreq", stallreq_o, 0);
      check("rs_cpu_data", cpu_data_o, 32'h0);
      tick();
      wb_ack_i = 1'b0; #1;
      check("rs_rdbuf_kept", cpu_data_o, 32'h0);
      check("rs_cyc_after",  wb_cyc_o,   0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
